// File: rtl/stage_wb.sv
// Writeback stage: MEM/WB pipeline register, architectural register file with
// write-first bypass on two read ports, and a retired-instruction counter.
module stage_wb #(
  parameter  int REG_NUM = 32,
  parameter  int CNT_W   = 32,
  localparam int AW      = $clog2(REG_NUM)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wb_stall,
  input  logic             wb_flush,
  input  logic             wb_i_valid,
  input  logic             wb_i_rfwe,
  input  logic [AW-1:0]    wb_i_rfwa,
  input  logic [31:0]      wb_i_res,
  input  logic [31:0]      wb_i_pc,
  input  logic [AW-1:0]    id_raddr1,
  input  logic [AW-1:0]    id_raddr2,
  output logic [31:0]      id_rdata1,
  output logic [31:0]      id_rdata2,
  output logic             wb_o_rfwe,
  output logic [AW-1:0]    wb_o_rfwa,
  output logic [31:0]      wb_o_res,
  output logic [31:0]      wb_o_pc,
  output logic             wb_o_valid,
  output logic [CNT_W-1:0] retire_cnt
);

  logic             valid_q, valid_d;
  logic             rfwe_q, rfwe_d;
  logic [AW-1:0]    rfwa_q, rfwa_d;
  logic [31:0]      res_q, res_d;
  logic [31:0]      pc_q, pc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rf_we;

  // r0 has no storage; it is hard-wired to zero in the read path.
  logic [31:0]      rf_q [1:REG_NUM-1];

  always_comb begin
    valid_d = valid_q;
    rfwe_d  = rfwe_q;
    rfwa_d  = rfwa_q;
    res_d   = res_q;
    pc_d    = pc_q;
    if (wb_flush) begin
      valid_d = 1'b0;
      rfwe_d  = 1'b0;
      rfwa_d  = '0;
      res_d   = '0;
      pc_d    = '0;
    end else if (!wb_stall) begin
      valid_d = wb_i_valid;
      rfwe_d  = wb_i_rfwe;
      rfwa_d  = wb_i_rfwa;
      res_d   = wb_i_res;
      pc_d    = wb_i_pc;
    end
  end

  // A departing instruction retires even when the slot is flushed behind it.
  assign cnt_d = cnt_q + CNT_W'(valid_q && !wb_stall);
  assign rf_we = valid_q && rfwe_q && (rfwa_q != '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      rfwe_q  <= 1'b0;
      rfwa_q  <= '0;
      res_q   <= '0;
      pc_q    <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      rfwe_q  <= rfwe_d;
      rfwa_q  <= rfwa_d;
      res_q   <= res_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

  genvar gi;
  generate
    for (gi = 1; gi < REG_NUM; gi++) begin : g_rf
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          rf_q[gi] <= '0;
        end else if (rf_we && (rfwa_q == AW'(gi))) begin
          rf_q[gi] <= res_q;
        end
      end
    end
  endgenerate

  logic [AW-1:0] raddr [2];
  logic [31:0]   rdata [2];

  assign raddr[0]  = id_raddr1;
  assign raddr[1]  = id_raddr2;
  assign id_rdata1 = rdata[0];
  assign id_rdata2 = rdata[1];

  generate
    for (gi = 0; gi < 2; gi++) begin : g_rd
      always_comb begin
        rdata[gi] = '0;
        if (raddr[gi] == '0) begin
          rdata[gi] = '0;
        end else if (valid_q && rfwe_q && (raddr[gi] == rfwa_q)) begin
          rdata[gi] = res_q;
        end else begin
          rdata[gi] = rf_q[raddr[gi]];
        end
      end
    end
  endgenerate

  assign wb_o_valid = valid_q;
  assign wb_o_rfwe  = rfwe_q;
  assign wb_o_rfwa  = rfwa_q;
  assign wb_o_res   = res_q;
  assign wb_o_pc    = pc_q;
  assign retire_cnt = cnt_q;

endmodule

// File: tb/tb_stage_wb.sv
// Scoreboard bench for stage_wb: a reference model predicts each cycle's
// outputs, which are queued at drive time and compared after the edge.
module tb_stage_wb;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wb_stall, wb_flush;
  logic          wb_i_valid, wb_i_rfwe;
  logic [4:0]    wb_i_rfwa;
  logic [31:0]   wb_i_res, wb_i_pc;
  logic [4:0]    id_raddr1, id_raddr2;
  logic [31:0]   id_rdata1, id_rdata2;
  logic          wb_o_rfwe, wb_o_valid;
  logic [4:0]    wb_o_rfwa;
  logic [31:0]   wb_o_res, wb_o_pc;
  logic [CW-1:0] retire_cnt;

  stage_wb #(.REG_NUM(32), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .wb_stall(wb_stall), .wb_flush(wb_flush),
    .wb_i_valid(wb_i_valid), .wb_i_rfwe(wb_i_rfwe), .wb_i_rfwa(wb_i_rfwa),
    .wb_i_res(wb_i_res), .wb_i_pc(wb_i_pc),
    .id_raddr1(id_raddr1), .id_raddr2(id_raddr2),
    .id_rdata1(id_rdata1), .id_rdata2(id_rdata2),
    .wb_o_rfwe(wb_o_rfwe), .wb_o_rfwa(wb_o_rfwa), .wb_o_res(wb_o_res),
    .wb_o_pc(wb_o_pc), .wb_o_valid(wb_o_valid), .retire_cnt(retire_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          v;
    logic          we;
    logic [4:0]    a;
    logic [31:0]   res;
    logic [31:0]   pc;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t exp_q[$];

  // reference model state
  logic          m_v, m_we;
  logic [4:0]    m_a;
  logic [31:0]   m_res, m_pc;
  logic [CW-1:0] m_cnt;
  logic [31:0]   m_rf [32];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [4:0] addr);
    if (addr == 5'd0) return 32'd0;
    if (m_v && m_we && addr == m_a) return m_res;
    return m_rf[addr];
  endfunction

  task automatic model_edge();
    if (!rst_n) begin
      m_v = 0; m_we = 0; m_a = 0; m_res = 0; m_pc = 0; m_cnt = 0;
      for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
    end else begin
      if (m_v && m_we && m_a != 5'd0) m_rf[m_a] = m_res;
      if (m_v && !wb_stall) m_cnt = m_cnt + 1'b1;
      if (wb_flush) begin
        m_v = 0; m_we = 0; m_a = 0; m_res = 0; m_pc = 0;
      end else if (!wb_stall) begin
        m_v = wb_i_valid; m_we = wb_i_rfwe; m_a = wb_i_rfwa;
        m_res = wb_i_res; m_pc = wb_i_pc;
      end
    end
  endtask

  // One clock: predict, queue, advance, pop and compare all outputs.
  task automatic step();
    exp_t e;
    model_edge();
    exp_q.push_back('{m_v, m_we, m_a, m_res, m_pc, m_cnt});
    @(posedge clk);
    #1;
    cyc++;
    if (exp_q.size() == 0) begin
      check("queue_empty", 32'd0, 32'd1);
      return;
    end
    e = exp_q.pop_front();
    $display("[TB] cyc %0d v=%0b we=%0b a=%0d res=%h pc=%h cnt=%0d rd1=%h rd2=%h",
             cyc, wb_o_valid, wb_o_rfwe, wb_o_rfwa, wb_o_res, wb_o_pc, retire_cnt,
             id_rdata1, id_rdata2);
    check("valid", {31'd0, wb_o_valid}, {31'd0, e.v});
    check("rfwe",  {31'd0, wb_o_rfwe},  {31'd0, e.we});
    check("rfwa",  {27'd0, wb_o_rfwa},  {27'd0, e.a});
    check("res",   wb_o_res, e.res);
    check("pc",    wb_o_pc,  e.pc);
    check("cnt",   {{(32-CW){1'b0}}, retire_cnt}, {{(32-CW){1'b0}}, e.cnt});
    check("rdata1", id_rdata1, m_read(id_raddr1));
    check("rdata2", id_rdata2, m_read(id_raddr2));
  endtask

  task automatic drive(input logic v, input logic we, input logic [4:0] a,
                       input logic [31:0] res, input logic [31:0] pc);
    wb_i_valid = v; wb_i_rfwe = we; wb_i_rfwa = a; wb_i_res = res; wb_i_pc = pc;
  endtask

  initial begin
    rst_n = 0; wb_stall = 0; wb_flush = 0;
    id_raddr1 = 0; id_raddr2 = 0;
    m_v = 0; m_we = 0; m_a = 0; m_res = 0; m_pc = 0; m_cnt = 0;
    for (int i = 0; i < 32; i++) m_rf[i] = 32'hFFFF_FFFF;
    // junk on inputs during reset must not leak through
    drive(1, 1, 5'd9, 32'hBAD0_BAD0, 32'h44);

    // reset, then sweep the register file
    step(); step();
    check("rst_cnt", {28'd0, retire_cnt}, 32'd0);
    check("rst_valid", {31'd0, wb_o_valid}, 32'd0);
    rst_n = 1;
    drive(0, 0, 0, 0, 0);
    step();
    for (int r = 1; r < 32; r++) begin
      id_raddr1 = 5'(r);
      id_raddr2 = 5'(32 - r);
      #1;
      check("rst_rd1", id_rdata1, 32'd0);
      check("rst_rd2", id_rdata2, 32'd0);
    end

    // basic writeback with bypass, then array read
    drive(1, 1, 5'd5, 32'hDEAD_BEEF, 32'h0040_0010);
    id_raddr1 = 5'd5; id_raddr2 = 5'd6;
    step();
    drive(0, 0, 0, 0, 0);
    check("basic_res", wb_o_res, 32'hDEAD_BEEF);
    check("basic_byp", id_rdata1, 32'hDEAD_BEEF);
    step();
    check("basic_arr", id_rdata1, 32'hDEAD_BEEF);
    check("basic_cnt", {28'd0, retire_cnt}, 32'd1);

    // r0 write discarded but counted
    drive(1, 1, 5'd0, 32'h1234_5678, 32'h0040_0014);
    id_raddr1 = 5'd0; id_raddr2 = 5'd0;
    step();
    drive(0, 0, 0, 0, 0);
    check("r0_byp", id_rdata1, 32'd0);
    step();
    check("r0_arr", id_rdata1, 32'd0);
    check("r0_cnt", {28'd0, retire_cnt}, 32'd2);

    // stall holds, then stall+flush drops without counting
    drive(1, 1, 5'd7, 32'hA5A5_A5A5, 32'h0040_0100);
    id_raddr1 = 5'd7; id_raddr2 = 5'd5;
    step();
    drive(1, 1, 5'd9, 32'h9999_9999, 32'h0040_0104);
    wb_stall = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_res", wb_o_res, 32'hA5A5_A5A5);
      check("stall_cnt", {28'd0, retire_cnt}, 32'd2);
    end
    wb_flush = 1;
    step();
    check("sf_valid", {31'd0, wb_o_valid}, 32'd0);
    check("sf_rfwe", {31'd0, wb_o_rfwe}, 32'd0);
    check("sf_r7", id_rdata1, 32'hA5A5_A5A5);
    check("sf_cnt", {28'd0, retire_cnt}, 32'd2);
    wb_stall = 0; wb_flush = 0;
    drive(0, 0, 0, 0, 0);
    step();

    // flush alone: departing valid instruction still retires
    drive(1, 1, 5'd8, 32'h0000_0808, 32'h0040_0200);
    step();
    drive(1, 1, 5'd10, 32'h0000_0A0A, 32'h0040_0204);
    wb_flush = 1;
    step();
    check("fl_valid", {31'd0, wb_o_valid}, 32'd0);
    check("fl_cnt", {28'd0, retire_cnt}, 32'd3);
    wb_flush = 0;

    // dual-port bypass vs array
    id_raddr1 = 5'd3; id_raddr2 = 5'd3;
    drive(1, 1, 5'd3, 32'h22, 32'h0040_0300);
    step();
    drive(1, 0, 5'd3, 32'h11, 32'h0040_0304);
    step();
    check("nobyp_rd1", id_rdata1, 32'h22);
    check("nobyp_rd2", id_rdata2, 32'h22);
    drive(1, 1, 5'd3, 32'h11, 32'h0040_0308);
    step();
    check("byp_rd1", id_rdata1, 32'h11);
    check("byp_rd2", id_rdata2, 32'h11);
    drive(0, 0, 0, 0, 0);
    step();

    // counter wrap over 17 retirements
    rst_n = 0;
    step();
    rst_n = 1;
    for (int k = 1; k <= 18; k++) begin
      if (k <= 17) drive(1, 0, 5'(k), 32'(k), 32'h0040_1000 + 32'(4 * k));
      else drive(0, 0, 0, 0, 0);
      step();
      check("wrap_cnt", {28'd0, retire_cnt}, 32'((k - 1) % 16));
    end
    check("wrap_end", {28'd0, retire_cnt}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
